// File: rtl/cpa_pipe_stage.sv
// Final carry-propagate stage: resolves a redundant sum/carry pair into a binary
// product via a two-stage split adder with valid/ready handshakes. Define CPA_COUT_EN for out_cout.
module cpa_pipe_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOW_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_product
`ifdef CPA_COUT_EN
  ,
  output logic             out_cout
`endif
);

  localparam int unsigned HI_W = WIDTH - LOW_W;

  // Carry vector bit i weighs 2^(i+1); its MSB falls outside the result.
  logic [WIDTH-1:0] b;
  logic             carry_msb_unused;
  assign b                = {in_carry[WIDTH-2:0], 1'b0};
  assign carry_msb_unused = in_carry[WIDTH-1];

  logic [LOW_W:0] lo_full;
  assign lo_full = {1'b0, in_sum[LOW_W-1:0]} + {1'b0, b[LOW_W-1:0]};

  logic             s1_valid;
  logic [LOW_W-1:0] s1_lo;
  logic             s1_c1;
  logic [HI_W-1:0]  s1_sum_hi;
  logic [HI_W-1:0]  s1_b_hi;

  logic             s2_valid;
  logic [LOW_W-1:0] s2_lo;
  logic [HI_W-1:0]  s2_hi;

  logic s1_adv;
  logic s2_adv;
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_lo     <= '0;
      s1_c1     <= 1'b0;
      s1_sum_hi <= '0;
      s1_b_hi   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo     <= lo_full[LOW_W-1:0];
        s1_c1     <= lo_full[LOW_W];
        s1_sum_hi <= in_sum[WIDTH-1:LOW_W];
        s1_b_hi   <= b[WIDTH-1:LOW_W];
      end
    end
  end

  logic [HI_W:0] hi_full;
  assign hi_full = {1'b0, s1_sum_hi} + {1'b0, s1_b_hi} + {{HI_W{1'b0}}, s1_c1};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_lo    <= '0;
      s2_hi    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lo <= s1_lo;
        s2_hi <= hi_full[HI_W-1:0];
      end
    end
  end

`ifdef CPA_COUT_EN
  logic s2_cout;
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_cout <= 1'b0;
    end else if (s2_adv && s1_valid) begin
      s2_cout <= hi_full[HI_W];
    end
  end
  assign out_cout = s2_cout;
`else
  logic hi_carry_unused;
  assign hi_carry_unused = hi_full[HI_W];
`endif

  assign out_valid   = s2_valid;
  assign out_product = {s2_hi, s2_lo};

endmodule

// File: tb/tb_cpa_pipe_stage.sv
// Self-checking bench for cpa_pipe_stage: queue-based reference model plus
// directed literal checks for latency, carry boundaries, backpressure and reset.
module tb_cpa_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic [15:0] in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
`ifdef CPA_COUT_EN
  logic        out_cout;
`endif

  cpa_pipe_stage #(.WIDTH(16), .LOW_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product)
`ifdef CPA_COUT_EN
    ,
    .out_cout   (out_cout)
`endif
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned pops     = 0;

  typedef struct packed {
    logic [15:0] product;
    logic        cout;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t model(input logic [15:0] s, input logic [15:0] c);
    int unsigned total;
    exp_t e;
    total     = int'(s) + (int'(c) % 32768) * 2;
    e.product = 16'(total % 65536);
    e.cout    = (total >= 65536);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor at the falling edge: inputs and outputs are stable for the next rising edge.
  logic        prev_hold = 1'b0;
  logic [15:0] prev_product;
  logic        prev_rst = 1'b1;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_hold <= 1'b0;
    end else begin
      if (prev_rst) begin
        chk("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
      end
      if (prev_hold) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_product", {16'b0, out_product}, {16'b0, prev_product});
      end
      if (out_valid && exp_q.size() == 0) begin
        chk("spurious_output", {31'b0, out_valid}, 32'd0);
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("model_product", {16'b0, out_product}, {16'b0, e.product});
`ifdef CPA_COUT_EN
        chk("model_cout", {31'b0, out_cout}, {31'b0, e.cout});
`endif
        pops++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_carry));
      prev_hold    <= out_valid && !out_ready;
      prev_product <= out_product;
    end
    prev_rst <= rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic latency_case(input string name, input logic [15:0] s, input logic [15:0] c,
                              input logic [15:0] prod, input logic co);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = s;
    in_carry  = c;
    #1;
    chk({name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
    step();
    chk({name, "_lat2_valid"}, {31'b0, out_valid}, 32'd1);
    chk({name, "_product"}, {16'b0, out_product}, {16'b0, prod});
`ifdef CPA_COUT_EN
    chk({name, "_cout"}, {31'b0, out_cout}, {31'b0, co});
`else
    if (co === 1'bx) $display("unreachable");
`endif
    step();
  endtask

  initial begin
    int unsigned bad_ready;
    int unsigned sent;
    int unsigned cycles;
    int unsigned start_pops;
    logic        fire;

    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; out_ready = 1'b0;
    step();
    step();
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_product", {16'b0, out_product}, 32'd0);
`ifdef CPA_COUT_EN
    chk("reset_cout", {31'b0, out_cout}, 32'd0);
`endif
    rst = 1'b0;

    // Pin the model itself.
    chk("model_pin_cross", {15'b0, model(16'h00FF, 16'h0001)}, {15'b0, 16'h0101, 1'b0});
    chk("model_pin_wrap", {15'b0, model(16'hFFFF, 16'h0001)}, {15'b0, 16'h0001, 1'b1});
    chk("model_pin_msb", {15'b0, model(16'h1234, 16'h8000)}, {15'b0, 16'h1234, 1'b0});

    latency_case("cross", 16'h00FF, 16'h0001, 16'h0101, 1'b0);
    latency_case("wrap", 16'hFFFF, 16'h0001, 16'h0001, 1'b1);
    latency_case("msb", 16'h1234, 16'h8000, 16'h1234, 1'b0);

    // Backpressure: capacity of two, third pair refused.
    out_ready = 1'b0;
    in_valid = 1'b1; in_sum = 16'd1; in_carry = '0;
    #1 chk("bp_ready1", {31'b0, in_ready}, 32'd1);
    step();
    in_sum = 16'd2;
    #1 chk("bp_ready2", {31'b0, in_ready}, 32'd1);
    step();
    in_sum = 16'd3;
    #1 chk("bp_ready3", {31'b0, in_ready}, 32'd0);
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_prod_a", {16'b0, out_product}, 32'd1);
    step();
    chk("bp_prod_b", {16'b0, out_product}, 32'd1);
    chk("bp_ready4", {31'b0, in_ready}, 32'd0);
    step();
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out2", {16'b0, out_product}, 32'd2);
    step();
    chk("bp_out3", {16'b0, out_product}, 32'd3);
    chk("bp_out3_valid", {31'b0, out_valid}, 32'd1);
    step();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Reset with two entries in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_sum = 16'hAAAA; in_carry = 16'h0101;
    step();
    in_sum = 16'h5555;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    step();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_stale", {31'b0, out_valid}, 32'd0);
    end

    // Streaming: one result per cycle.
    start_pops = pops;
    bad_ready  = 0;
    in_valid   = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_sum   = 16'($urandom);
      in_carry = 16'($urandom);
      #1 if (!in_ready) bad_ready++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_ready_drops", bad_ready, 32'd0);
    chk("stream_pops_during", pops - start_pops, 32'd254);
    step();
    step();
    chk("stream_pops_total", pops - start_pops, 32'd256);

    // Random valid/ready toggling.
    sent = 0; cycles = 0; in_valid = 1'b0;
    while (sent < 10000 && cycles < 60000) begin
      if (!in_valid && $urandom_range(0, 9) < 7) begin
        in_valid = 1'b1;
        in_sum   = 16'($urandom);
        in_carry = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1 fire = in_valid && in_ready;
      step();
      cycles++;
      if (fire) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("random_sent", sent, 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("random_drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
